// File: rtl/pc_fetch_stage.sv
// ---------------------------------------------------------------------------
// pc_fetch_stage
//   Program-counter register and fetch-valid control for the IF stage.
//   The PC is loaded from next_pc, which comes from the external next-PC mux:
//   pc_plus4 on sequential flow, branch target on a taken branch. After a
//   redirect the stage inserts SQUASH_CYCLES bubbles (if_valid=0), and it
//   holds everything while stall is high.
//
//   Optional feature macro: PC_PERF_CNT_EN adds the fetch_cnt / bubble_cnt
//   performance counters. With the macro undefined the ports do not exist.
//
// Parameters
//   RESET_PC       PC value loaded on reset
//   SQUASH_CYCLES  bubble cycles after a redirect (1..7)
//
// Ports
//   clk           in   clock, all state updates on posedge
//   reset         in   synchronous active-high reset
//   next_pc       in   [63:0] next-PC mux output
//   redirect      in   taken branch resolved; next_pc holds the target
//   stall         in   hazard stall; hold PC and fetch state
//   pc            out  [63:0] current fetch address
//   pc_plus4      out  [63:0] pc + 4 (combinational, wraps)
//   if_valid      out  fetch at pc is on the correct path
//   misalign_err  out  sticky: a misaligned next_pc was loaded
//   dbg_state     out  [1:0] FSM state (0=BOOT, 1=RUN, 2=SQUASH)
//   fetch_cnt     out  [63:0] cycles with if_valid && !stall (PC_PERF_CNT_EN)
//   bubble_cnt    out  [31:0] cycles spent in SQUASH          (PC_PERF_CNT_EN)
//
// Handshake: there is no valid/ready pair here; stall is a pure hold that
// freezes pc, if_valid, state and the squash counter for that cycle, and
// redirect always takes priority over stall.
// ---------------------------------------------------------------------------
module pc_fetch_stage #(
    parameter logic [63:0] RESET_PC      = 64'h0,
    parameter int          SQUASH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] next_pc,
    input  logic        redirect,
    input  logic        stall,
    output logic [63:0] pc,
    output logic [63:0] pc_plus4,
    output logic        if_valid,
    output logic        misalign_err,
`ifdef PC_PERF_CNT_EN
    output logic [63:0] fetch_cnt,
    output logic [31:0] bubble_cnt,
`endif
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SQUASH = 2'd2
    } state_t;

    // Counter reload: squash_cnt counts down to 0, so the number of bubble
    // cycles equals SQUASH_CYCLES.
    localparam logic [2:0] SQ_RELOAD = 3'(SQUASH_CYCLES - 1);

    state_t      st;
    logic [2:0]  squash_cnt;
    logic        load_pc;
    logic [63:0] aligned_next;
    logic        next_misaligned;

    assign pc_plus4        = pc + 64'd4;
    assign aligned_next    = {next_pc[63:2], 2'b00};
    assign next_misaligned = |next_pc[1:0];
    assign dbg_state       = st;

    // pc reloads on a redirect in RUN or SQUASH, or on a plain advance in
    // RUN. BOOT never loads; the SQUASH exit cycle never loads either, so
    // the branch target itself becomes the first valid fetch.
    always_comb begin
        load_pc = 1'b0;
        case (st)
            ST_RUN:    load_pc = redirect || !stall;
            ST_SQUASH: load_pc = redirect;
            default:   load_pc = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st           <= ST_BOOT;
            pc           <= RESET_PC;
            if_valid     <= 1'b0;
            misalign_err <= 1'b0;
            squash_cnt   <= 3'd0;
        end else begin
            if (load_pc) begin
                pc <= aligned_next;
                if (next_misaligned) begin
                    misalign_err <= 1'b1;
                end
            end

            case (st)
                ST_BOOT: begin
                    st       <= ST_RUN;
                    if_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (redirect) begin
                        st         <= ST_SQUASH;
                        if_valid   <= 1'b0;
                        squash_cnt <= SQ_RELOAD;
                    end
                end
                ST_SQUASH: begin
                    if (redirect) begin
                        squash_cnt <= SQ_RELOAD;
                    end else if (stall) begin
                        squash_cnt <= squash_cnt;
                    end else if (squash_cnt == 3'd0) begin
                        st       <= ST_RUN;
                        if_valid <= 1'b1;
                    end else begin
                        squash_cnt <= squash_cnt - 3'd1;
                    end
                end
                default: begin
                    st       <= ST_BOOT;
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_PERF_CNT_EN
    // Counters sample the current registered state, so they advance on the
    // same edge as the FSM that they observe.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt  <= 64'd0;
            bubble_cnt <= 32'd0;
        end else begin
            if (if_valid && !stall) begin
                fetch_cnt <= fetch_cnt + 64'd1;
            end
            if (st == ST_SQUASH) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
module tb_pc_fetch_stage;

    localparam logic [1:0] S_BOOT   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_SQUASH = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT A: SQUASH_CYCLES = 1 ----------------
    logic        a_reset = 1'b1;
    logic        a_redirect = 1'b0;
    logic        a_stall = 1'b0;
    logic        a_use_p4 = 1'b1;
    logic [63:0] a_np_drv = 64'd0;
    logic [63:0] a_next_pc;
    logic [63:0] a_pc, a_pc_plus4;
    logic        a_if_valid, a_err;
    logic [1:0]  a_state;
`ifdef PC_PERF_CNT_EN
    logic [63:0] a_fetch_cnt;
    logic [31:0] a_bubble_cnt;
`endif

    // Sequential flow: feed pc_plus4 back through the "mux" like the CPU does.
    assign a_next_pc = a_use_p4 ? a_pc_plus4 : a_np_drv;

    pc_fetch_stage #(.RESET_PC(64'h0), .SQUASH_CYCLES(1)) dut_a (
        .clk          (clk),
        .reset        (a_reset),
        .next_pc      (a_next_pc),
        .redirect     (a_redirect),
        .stall        (a_stall),
        .pc           (a_pc),
        .pc_plus4     (a_pc_plus4),
        .if_valid     (a_if_valid),
        .misalign_err (a_err),
`ifdef PC_PERF_CNT_EN
        .fetch_cnt    (a_fetch_cnt),
        .bubble_cnt   (a_bubble_cnt),
`endif
        .dbg_state    (a_state)
    );

    // ---------------- DUT B: SQUASH_CYCLES = 3 ----------------
    logic        b_reset = 1'b1;
    logic        b_redirect = 1'b0;
    logic        b_stall = 1'b0;
    logic [63:0] b_next_pc = 64'd0;
    logic [63:0] b_pc, b_pc_plus4;
    logic        b_if_valid, b_err;
    logic [1:0]  b_state;
`ifdef PC_PERF_CNT_EN
    logic [63:0] b_fetch_cnt;
    logic [31:0] b_bubble_cnt;
`endif

    pc_fetch_stage #(.RESET_PC(64'h0), .SQUASH_CYCLES(3)) dut_b (
        .clk          (clk),
        .reset        (b_reset),
        .next_pc      (b_next_pc),
        .redirect     (b_redirect),
        .stall        (b_stall),
        .pc           (b_pc),
        .pc_plus4     (b_pc_plus4),
        .if_valid     (b_if_valid),
        .misalign_err (b_err),
`ifdef PC_PERF_CNT_EN
        .fetch_cnt    (b_fetch_cnt),
        .bubble_cnt   (b_bubble_cnt),
`endif
        .dbg_state    (b_state)
    );

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        reset;
        logic        redirect;
        logic        stall;
        logic        use_p4;
        logic [63:0] next_pc;
        logic [63:0] exp_pc;
        logic        exp_valid;
        logic        exp_err;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, input logic rd, input logic st, input logic p4,
                                input logic [63:0] np, input logic [63:0] epc,
                                input logic ev, input logic ee, input logic [1:0] es);
        vec_t v;
        v.reset = r; v.redirect = rd; v.stall = st; v.use_p4 = p4; v.next_pc = np;
        v.exp_pc = epc; v.exp_valid = ev; v.exp_err = ee; v.exp_state = es;
        return v;
    endfunction

    // ---------------- driver for DUT B ----------------
    task automatic b_step(input logic r, input logic rd, input logic st, input logic [63:0] np);
        b_reset = r; b_redirect = rd; b_stall = st; b_next_pc = np;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_bub;
        //            rst rd st p4 next_pc                exp_pc                 v  e  state
        vq.push_back(mk(1, 0, 0, 1, 64'h0,                64'h0,                 0, 0, S_BOOT));   // 0  reset
        vq.push_back(mk(0, 0, 0, 1, 64'h0,                64'h0,                 1, 0, S_RUN));    // 1  first fetch at RESET_PC
        vq.push_back(mk(0, 0, 0, 1, 64'h0,                64'h4,                 1, 0, S_RUN));    // 2
        vq.push_back(mk(0, 0, 0, 1, 64'h0,                64'h8,                 1, 0, S_RUN));    // 3
        vq.push_back(mk(0, 0, 0, 1, 64'h0,                64'hC,                 1, 0, S_RUN));    // 4
        vq.push_back(mk(0, 0, 0, 1, 64'h0,                64'h10,                1, 0, S_RUN));    // 5
        vq.push_back(mk(0, 1, 0, 0, 64'h100,              64'h100,               0, 0, S_SQUASH)); // 6  redirect
        vq.push_back(mk(0, 0, 0, 1, 64'h0,                64'h100,               1, 0, S_RUN));    // 7  target is first valid
        vq.push_back(mk(0, 0, 0, 1, 64'h0,                64'h104,               1, 0, S_RUN));    // 8
        vq.push_back(mk(0, 1, 0, 0, 64'h20,               64'h20,                0, 0, S_SQUASH)); // 9
        vq.push_back(mk(0, 0, 0, 1, 64'h0,                64'h20,                1, 0, S_RUN));    // 10
        vq.push_back(mk(0, 0, 1, 1, 64'h0,                64'h20,                1, 0, S_RUN));    // 11 stall
        vq.push_back(mk(0, 0, 1, 1, 64'h0,                64'h20,                1, 0, S_RUN));    // 12 stall
        vq.push_back(mk(0, 0, 1, 1, 64'h0,                64'h20,                1, 0, S_RUN));    // 13 stall
        vq.push_back(mk(0, 1, 1, 0, 64'h40,               64'h40,                0, 0, S_SQUASH)); // 14 redirect beats stall
        vq.push_back(mk(0, 0, 1, 1, 64'h0,                64'h40,                0, 0, S_SQUASH)); // 15 stall freezes squash
        vq.push_back(mk(0, 0, 0, 1, 64'h0,                64'h40,                1, 0, S_RUN));    // 16
        vq.push_back(mk(0, 0, 0, 0, 64'h1002,             64'h1000,              1, 1, S_RUN));    // 17 misaligned load
        vq.push_back(mk(0, 0, 0, 1, 64'h0,                64'h1004,              1, 1, S_RUN));    // 18 sticky
        vq.push_back(mk(0, 1, 0, 0, 64'h2000,             64'h2000,              0, 1, S_SQUASH)); // 19
        vq.push_back(mk(0, 0, 0, 1, 64'h0,                64'h2000,              1, 1, S_RUN));    // 20
        vq.push_back(mk(0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, S_SQUASH)); // 21
        vq.push_back(mk(0, 0, 0, 1, 64'h0,                64'hFFFF_FFFF_FFFF_FFFC, 1, 1, S_RUN));  // 22 pc_plus4 wraps
        vq.push_back(mk(0, 0, 0, 1, 64'h0,                64'h0,                 1, 1, S_RUN));    // 23 wrapped
        vq.push_back(mk(1, 0, 0, 1, 64'h0,                64'h0,                 0, 0, S_BOOT));   // 24 reset clears sticky
        vq.push_back(mk(0, 1, 0, 0, 64'h503,              64'h0,                 1, 0, S_RUN));    // 25 redirect in BOOT ignored
        vq.push_back(mk(0, 1, 0, 0, 64'h600,              64'h600,               0, 0, S_SQUASH)); // 26
        vq.push_back(mk(1, 1, 0, 0, 64'h703,              64'h0,                 0, 0, S_BOOT));   // 27 reset mid-squash wins
        vq.push_back(mk(0, 0, 0, 1, 64'h0,                64'h0,                 1, 0, S_RUN));    // 28

        @(negedge clk);
        foreach (vq[i]) begin
            a_reset    = vq[i].reset;
            a_redirect = vq[i].redirect;
            a_stall    = vq[i].stall;
            a_use_p4   = vq[i].use_p4;
            a_np_drv   = vq[i].next_pc;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d pc", i),       a_pc,               vq[i].exp_pc);
            check($sformatf("vec%0d pc_plus4", i), a_pc_plus4,         vq[i].exp_pc + 64'd4);
            check($sformatf("vec%0d if_valid", i), 64'(a_if_valid),    64'(vq[i].exp_valid));
            check($sformatf("vec%0d misalign", i), 64'(a_err),         64'(vq[i].exp_err));
            check($sformatf("vec%0d state", i),    64'(a_state),       64'(vq[i].exp_state));
        end
        check("wrap pc_plus4 literal", 64'(a_pc == 64'hFFFF_FFFF_FFFF_FFFC), 64'd0);

        // ---------- DUT B: SQUASH_CYCLES=3, stall inside the squash window ----------
        b_step(1, 0, 0, 64'h0);
        check("b reset pc", b_pc, 64'h0);
        check("b reset state", 64'(b_state), 64'(S_BOOT));
`ifdef PC_PERF_CNT_EN
        check("b reset fetch_cnt", b_fetch_cnt, 64'd0);
        check("b reset bubble_cnt", 64'(b_bubble_cnt), 64'd0);
`endif
        b_step(0, 0, 0, 64'h0);
        check("b run valid", 64'(b_if_valid), 64'd1);

        n_bub = 0;
        b_step(0, 1, 0, 64'h200);
        if (b_if_valid == 1'b0) n_bub++;
        check("b sq1 pc", b_pc, 64'h200);
        b_step(0, 0, 0, 64'h0);
        if (b_if_valid == 1'b0) n_bub++;
        check("b sq2 pc", b_pc, 64'h200);
        b_step(0, 0, 1, 64'h0);
        if (b_if_valid == 1'b0) n_bub++;
        check("b sq3 pc", b_pc, 64'h200);
        for (int k = 0; k < 10; k++) begin
            b_step(0, 0, 0, 64'h0);
            if (b_if_valid == 1'b1) break;
            n_bub++;
            check("b sq pc hold", b_pc, 64'h200);
        end
        check("b bubbles with stall", 64'(n_bub), 64'd4);
        check("b exit valid", 64'(b_if_valid), 64'd1);
        check("b exit pc", b_pc, 64'h200);
        check("b exit state", 64'(b_state), 64'(S_RUN));
`ifdef PC_PERF_CNT_EN
        check("b fetch_cnt", b_fetch_cnt, 64'd1);
        check("b bubble_cnt", 64'(b_bubble_cnt), 64'd4);
`endif

        // second redirect in mid-squash restarts the bubble count
        b_step(0, 1, 0, 64'h280);
        b_step(0, 0, 0, 64'h0);
        n_bub = 0;
        b_step(0, 1, 0, 64'h300);
        if (b_if_valid == 1'b0) n_bub++;
        check("b re-redirect pc", b_pc, 64'h300);
        for (int k = 0; k < 10; k++) begin
            b_step(0, 0, 0, 64'h0);
            if (b_if_valid == 1'b1) break;
            n_bub++;
            check("b re-sq pc hold", b_pc, 64'h300);
        end
        check("b bubbles after restart", 64'(n_bub), 64'd3);
        check("b restart exit pc", b_pc, 64'h300);
        check("b restart exit valid", 64'(b_if_valid), 64'd1);

        // reset while squashing
        b_step(0, 1, 0, 64'h400);
        check("b pre-reset state", 64'(b_state), 64'(S_SQUASH));
        b_step(1, 0, 0, 64'h0);
        check("b midsq reset pc", b_pc, 64'h0);
        check("b midsq reset state", 64'(b_state), 64'(S_BOOT));
        check("b midsq reset valid", 64'(b_if_valid), 64'd0);
`ifdef PC_PERF_CNT_EN
        check("b midsq fetch_cnt", b_fetch_cnt, 64'd0);
        check("b midsq bubble_cnt", 64'(b_bubble_cnt), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
